// File: rtl/loadable_ram_pkg.sv
// rtl/loadable_ram_pkg.sv - shared state encoding and default sizes for loadable_ram
package loadable_ram_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_CLEAR = 2'd2
  } state_e;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 8;

endpackage

// File: rtl/ram_sp_core.sv
// rtl/ram_sp_core.sv - storage array, one write port, registered read-first read port
module ram_sp_core #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  input  logic              rd_zero,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Non-blocking read of the array gives read-first behaviour on a same-address write.
  always_ff @(posedge clk) begin
    if (!rst_n || rd_zero) begin
      rdata <= '0;
    end else begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/loadable_ram.sv
// rtl/loadable_ram.sv - CPU memory with stream loader; LOADABLE_RAM_CLEAR_EN adds clear-on-reset
module loadable_ram
  import loadable_ram_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] d_i,
  output logic [DATA_W-1:0] d_o,
  input  logic              load_start,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  output logic              ld_ready,
  output logic              loading,
  output logic              load_done,
  output logic              load_ovf,
  output logic [ADDR_W:0]   load_count
);

  localparam logic [ADDR_W-1:0] PTR_MAX = '1;
  localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);
  localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W + 1)'(1);
`ifdef LOADABLE_RAM_CLEAR_EN
  localparam state_e RESET_STATE = ST_CLEAR;
`else
  localparam state_e RESET_STATE = ST_IDLE;
`endif

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              done_q, done_d;
  logic              ovf_q, ovf_d;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic              rd_zero;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= RESET_STATE;
      ptr_q   <= '0;
      count_q <= '0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      count_q <= count_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    count_d   = count_q;
    done_d    = done_q;
    ovf_d     = ovf_q;
    mem_we    = 1'b0;
    mem_waddr = addr;
    mem_wdata = d_i;
    ld_ready  = 1'b0;
    loading   = 1'b0;
    rd_zero   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        mem_we = we;
        if (load_start) begin
          state_d = ST_LOAD;
          ptr_d   = '0;
          count_d = '0;
          done_d  = 1'b0;
          ovf_d   = 1'b0;
        end
      end
      ST_LOAD: begin
        ld_ready  = 1'b1;
        loading   = 1'b1;
        mem_waddr = ptr_q;
        mem_wdata = ld_data;
        if (ld_valid) begin
          mem_we  = 1'b1;
          count_d = count_q + CNT_ONE;
          // The pointer saturates at the top word; a full memory ends the load.
          if (ptr_q != PTR_MAX) begin
            ptr_d = ptr_q + PTR_ONE;
          end
          if (ld_last) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else if (ptr_q == PTR_MAX) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
            ovf_d   = 1'b1;
          end
        end
      end
`ifdef LOADABLE_RAM_CLEAR_EN
      ST_CLEAR: begin
        loading   = 1'b1;
        rd_zero   = 1'b1;
        mem_we    = 1'b1;
        mem_waddr = ptr_q;
        mem_wdata = '0;
        if (ptr_q == PTR_MAX) begin
          state_d = ST_IDLE;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + PTR_ONE;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  assign load_done  = done_q;
  assign load_ovf   = ovf_q;
  assign load_count = count_q;

  ram_sp_core #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_core (
    .clk    (clk),
    .rst_n  (rst_n),
    .we     (mem_we & rst_n),
    .waddr  (mem_waddr),
    .wdata  (mem_wdata),
    .raddr  (addr),
    .rd_zero(rd_zero),
    .rdata  (d_o)
  );

endmodule
